// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives the value and start request; the slave returns status and packed BCD.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 7,
  parameter int DIGITS    = 2
) ();
  logic [BIN_WIDTH-1:0] i_Binary;
  logic                 i_Start;
  logic                 o_Busy;
  logic                 o_Done;
  logic [4*DIGITS-1:0]  o_BCD;
  logic                 o_Overflow;

  modport master (
    output i_Binary,
    output i_Start,
    input  o_Busy,
    input  o_Done,
    input  o_BCD,
    input  o_Overflow
  );

  modport slave (
    input  i_Binary,
    input  i_Start,
    output o_Busy,
    output o_Done,
    output o_BCD,
    output o_Overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter; holds the packed digits between conversions.
// Optional BCD_AUTO_START_EN: start a conversion automatically whenever i_Binary changes while idle.
//
// state   | meaning
// S_IDLE  | waiting for a start; results held
// S_SHIFT | one add-3/shift step per cycle, BIN_WIDTH cycles
// S_DONE  | publish digits and overflow, pulse o_Done
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 7,
  parameter int DIGITS    = 2
) (
  input logic              i_Clk,
  input logic              i_Reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BIN_WIDTH-1:0] bin_d;
  logic [SW-1:0]        scr_q;
  logic [SW-1:0]        scr_d;
  logic [SW-1:0]        adj_d;
  logic                 sticky_q;
  logic                 sticky_d;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic                 ovf_q;
  logic                 start_d;

  always_comb begin
    adj_d = scr_q;
    for (int k = 0; k <= DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) begin
        adj_d[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      end
    end
    scr_d    = {adj_d[SW-2:0], bin_q[BIN_WIDTH-1]};
    bin_d    = bin_q << 1;
    sticky_d = sticky_q | adj_d[SW-1];
  end

`ifdef BCD_AUTO_START_EN
  logic [BIN_WIDTH-1:0] last_q;
  assign start_d = bus.i_Start | (bus.i_Binary != last_q);
`else
  assign start_d = bus.i_Start;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      scr_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef BCD_AUTO_START_EN
      last_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            bin_q    <= bus.i_Binary;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CW'(BIN_WIDTH);
            busy_q   <= 1'b1;
            state_q  <= S_SHIFT;
`ifdef BCD_AUTO_START_EN
            last_q   <= bus.i_Binary;
`endif
          end
        end
        S_SHIFT: begin
          scr_q    <= scr_d;
          bin_q    <= bin_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Guard digit catches values >= 10^DIGITS; sticky covers bits lost past it.
          bcd_q   <= scr_q[4*DIGITS-1:0];
          ovf_q   <= (scr_q[SW-1 -: 4] != 4'd0) | sticky_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Busy     = busy_q;
  assign bus.o_Done     = done_q;
  assign bus.o_BCD      = bcd_q;
  assign bus.o_Overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_WIDTH=7, DIGITS=2).
// Covers latency, busy window, overflow, ignored starts, back-to-back starts and mid-conversion reset.
module tb_bin_to_bcd_seq;

  logic i_Clk = 1'b0;
  logic i_Reset;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  bin_to_bcd_seq_if #(.BIN_WIDTH(7), .DIGITS(2)) bus_if ();

  bin_to_bcd_seq #(.BIN_WIDTH(7), .DIGITS(2)) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus_if.slave)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge (E0); returns o_Busy sampled just after E0.
  task automatic start_conv(input logic [6:0] v, output int busy0);
    bus_if.i_Binary = v;
    bus_if.i_Start  = 1'b1;
    @(posedge i_Clk);
    #1;
    bus_if.i_Start  = 1'b0;
    busy0 = int'(bus_if.o_Busy);
  endtask

  // Edges until o_Done (-1 on timeout), busy samples before it, and whether o_BCD stayed put.
  task automatic wait_done(output int n, output int busy_n, output int stable);
    logic [7:0] b0;
    bit got;
    b0 = bus_if.o_BCD;
    n = 0; busy_n = 0; stable = 1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge i_Clk);
      #1;
      n++;
      if (bus_if.o_Done === 1'b1) got = 1'b1;
      else begin
        if (bus_if.o_Busy === 1'b1) busy_n++;
        if (bus_if.o_BCD !== b0) stable = 0;
      end
    end
    if (!got) n = -1;
  endtask

  task automatic count_done(input int edges, output int cnt);
    cnt = 0;
    for (int k = 0; k < edges; k++) begin
      @(posedge i_Clk);
      #1;
      if (bus_if.o_Done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int b0, n, bn, st, dc;
    i_Reset         = 1'b1;
    bus_if.i_Binary = '0;
    bus_if.i_Start  = 1'b0;
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_busy", 32'(bus_if.o_Busy), 32'd0);
    chk("rst_done", 32'(bus_if.o_Done), 32'd0);
    chk("rst_bcd",  32'(bus_if.o_BCD), 32'h00);
    chk("rst_ovf",  32'(bus_if.o_Overflow), 32'd0);
    i_Reset = 1'b0;
    @(posedge i_Clk);
    #1;

    // 0
    start_conv(7'd0, b0);
    wait_done(n, bn, st);
    chk("zero_lat", 32'(n), 32'd8);
    chk("zero_bcd", 32'(bus_if.o_BCD), 32'h00);
    chk("zero_ovf", 32'(bus_if.o_Overflow), 32'd0);
    @(posedge i_Clk);
    #1;
    chk("zero_done_1cyc", 32'(bus_if.o_Done), 32'd0);

    // 99: busy window and held output
    start_conv(7'd99, b0);
    wait_done(n, bn, st);
    chk("99_lat", 32'(n), 32'd8);
    chk("99_busy_cycles", 32'(b0 + bn), 32'd8);
    chk("99_busy_in_done", 32'(bus_if.o_Busy), 32'd0);
    chk("99_bcd_stable", 32'(st), 32'd1);
    chk("99_bcd", 32'(bus_if.o_BCD), 32'h99);
    chk("99_ovf", 32'(bus_if.o_Overflow), 32'd0);
    repeat (3) @(posedge i_Clk);
    #1;
    chk("99_bcd_held", 32'(bus_if.o_BCD), 32'h99);

    // 127 overflows, then 5 clears it
    start_conv(7'd127, b0);
    wait_done(n, bn, st);
    chk("127_bcd", 32'(bus_if.o_BCD), 32'h27);
    chk("127_ovf", 32'(bus_if.o_Overflow), 32'd1);
    @(posedge i_Clk);
    #1;
    start_conv(7'd5, b0);
    wait_done(n, bn, st);
    chk("5_bcd", 32'(bus_if.o_BCD), 32'h05);
    chk("5_ovf", 32'(bus_if.o_Overflow), 32'd0);

    // 57 with a start of 42 at edge 3 that must be ignored
    start_conv(7'd57, b0);
    repeat (2) @(posedge i_Clk);
    #1;
    bus_if.i_Binary = 7'd42;
    bus_if.i_Start  = 1'b1;
    @(posedge i_Clk);
    #1;
    bus_if.i_Start  = 1'b0;
    count_done(4, dc);
    chk("57_early_done", 32'(dc), 32'd0);
    @(posedge i_Clk);
    #1;
    chk("57_done_e8", 32'(bus_if.o_Done), 32'd1);
    chk("57_bcd", 32'(bus_if.o_BCD), 32'h57);
    // start in the o_Done cycle
    start_conv(7'd42, b0);
    wait_done(n, bn, st);
    chk("42_b2b_lat", 32'(n), 32'd8);
    chk("42_bcd", 32'(bus_if.o_BCD), 32'h42);
    count_done(12, dc);
    chk("42_no_extra_done", 32'(dc), 32'd0);

    // reset at edge 4 of a conversion of 88
    start_conv(7'd88, b0);
    repeat (4) @(posedge i_Clk);
    #1;
    i_Reset = 1'b1;
    bus_if.i_Binary = 7'd0;
    #1;
    chk("abort_busy", 32'(bus_if.o_Busy), 32'd0);
    chk("abort_bcd", 32'(bus_if.o_BCD), 32'h00);
    chk("abort_ovf", 32'(bus_if.o_Overflow), 32'd0);
    chk("abort_done", 32'(bus_if.o_Done), 32'd0);
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    count_done(12, dc);
    chk("abort_no_done", 32'(dc), 32'd0);
    start_conv(7'd5, b0);
    wait_done(n, bn, st);
    chk("post_abort_lat", 32'(n), 32'd8);
    chk("post_abort_bcd", 32'(bus_if.o_BCD), 32'h05);

`ifdef BCD_AUTO_START_EN
    @(posedge i_Clk);
    #1;
    bus_if.i_Binary = 7'd12;
    wait_done(n, bn, st);
    chk("auto_12_lat", 32'(n), 32'd9);
    chk("auto_12_bcd", 32'(bus_if.o_BCD), 32'h12);
    @(posedge i_Clk);
    #1;
    bus_if.i_Binary = 7'd13;
    wait_done(n, bn, st);
    chk("auto_13_lat", 32'(n), 32'd9);
    chk("auto_13_bcd", 32'(bus_if.o_BCD), 32'h13);
    count_done(20, dc);
    chk("auto_hold_no_done", 32'(dc), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
